// File: rtl/frame_stage_sequencer.sv
// Multi-cycle fetch/decode/setup/execute/memory/writeback sequencer with memory
// handshake, timeout fault, halt and retired-instruction count. Optional macro: SEQ_SKIP_MEMREAD_EN.
module frame_stage_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   halt,
  input  logic                   instr_is_load,
  input  logic                   instr_is_store,
  input  logic                   mem_ready,
  output logic [2:0]             state,
  output logic                   mem_req,
  output logic                   mem_rd,
  output logic                   mem_wr,
  output logic                   cir_we,
  output logic                   decode_we,
  output logic                   operand_we,
  output logic                   result_we,
  output logic                   pc_we,
  output logic                   busy,
  output logic                   fault,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  localparam int unsigned WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    FETCH_REQ  = 3'd0,
    FETCH_RECV = 3'd1,
    DECODE     = 3'd2,
    SETUP      = 3'd3,
    EXECUTE    = 3'd4,
    MEMREAD    = 3'd5,
    WRITEBACK  = 3'd6,
    HALTED     = 3'd7
  } state_e;

  state_e                 state_q, state_d;
  logic                   fault_q, fault_d;
  logic [WCW-1:0]         wait_q, wait_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic is_mem, is_store, is_load, in_wait, timeout_hit;

  // Both flags set is treated as a store.
  assign is_mem   = instr_is_load | instr_is_store;
  assign is_store = instr_is_store;
  assign is_load  = instr_is_load & ~instr_is_store;
  assign in_wait  = (state_q == FETCH_RECV) || ((state_q == MEMREAD) && is_mem);
  assign timeout_hit = (MEM_TIMEOUT != 0) && in_wait && !mem_ready &&
                       (wait_q == WCW'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH_REQ;
      fault_q <= 1'b0;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    wait_d  = '0;
    count_d = count_q;
    if (fault_q) begin
      wait_d = wait_q;
    end else if (timeout_hit) begin
      fault_d = 1'b1;
      wait_d  = wait_q;
    end else begin
      // Counter is zero on the first cycle of every wait state since it clears elsewhere.
      if (in_wait && !mem_ready) wait_d = wait_q + 1'b1;
      unique case (state_q)
        FETCH_REQ:  state_d = FETCH_RECV;
        FETCH_RECV: if (mem_ready) state_d = DECODE;
        DECODE:     state_d = SETUP;
        SETUP:      state_d = EXECUTE;
        EXECUTE: begin
`ifdef SEQ_SKIP_MEMREAD_EN
          state_d = is_mem ? MEMREAD : WRITEBACK;
`else
          state_d = MEMREAD;
`endif
        end
        MEMREAD:    if (!is_mem || mem_ready) state_d = WRITEBACK;
        WRITEBACK: begin
          count_d = count_q + 1'b1;
          state_d = halt ? HALTED : FETCH_REQ;
        end
        HALTED:     if (!halt) state_d = FETCH_REQ;
        default:    state_d = FETCH_REQ;
      endcase
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    cir_we     = 1'b0;
    decode_we  = 1'b0;
    operand_we = 1'b0;
    result_we  = 1'b0;
    pc_we      = 1'b0;
    busy       = 1'b0;
    if (!reset && !fault_q) begin
      busy = (state_q != HALTED);
      unique case (state_q)
        FETCH_REQ: begin
          mem_req = 1'b1;
          mem_rd  = 1'b1;
        end
        FETCH_RECV: begin
          mem_req = 1'b1;
          mem_rd  = 1'b1;
          cir_we  = mem_ready;
        end
        DECODE:  decode_we  = 1'b1;
        SETUP:   operand_we = 1'b1;
        EXECUTE: begin
          result_we = 1'b1;
          pc_we     = 1'b1;
        end
        MEMREAD: if (is_mem) begin
          mem_req   = 1'b1;
          mem_rd    = is_load;
          mem_wr    = is_store;
          result_we = is_load & mem_ready;
        end
        default: ;
      endcase
    end
  end

  assign state       = state_q;
  assign fault       = fault_q & ~reset;
  assign instr_count = reset ? '0 : count_q;

endmodule
